// File: rtl/mod_check_sched_if.sv
// Request/result handshake bundle shared by the two requesters, the result
// consumer and the mod_check_sched engine.
interface mod_check_sched_if #(
    parameter int W   = 8,
    parameter int DIV = 5
);
    localparam int RW = $clog2(DIV);

    logic          req0_valid;
    logic [W-1:0]  req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [W-1:0]  req1_data;
    logic          req1_ready;
    logic          res_valid;
    logic          res_ready;
    logic [RW-1:0] res_rem;
    logic          res_div;
    logic          res_id;
    logic          busy;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, res_ready,
        output req0_ready, req1_ready, res_valid, res_rem, res_div, res_id, busy
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, res_ready,
        input  req0_ready, req1_ready, res_valid, res_rem, res_div, res_id, busy
    );
endinterface

// File: rtl/mod_check_sched.sv
// Round-robin front end sharing one bit-serial modulo-DIV remainder engine
// between two requesters; returns remainder, divisible flag and owner id.
//
//   state    | meaning
//   ST_IDLE  | waiting for a request, grant decided combinationally
//   ST_SHIFT | W recurrence steps, then one step latching the result
//   ST_DONE  | result presented, held until res_ready
module mod_check_sched #(
    parameter int W   = 8,
    parameter int DIV = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    mod_check_sched_if.slave bus
);
    localparam int RW  = $clog2(DIV);
    localparam int RW1 = RW + 1;
    localparam int CW  = $clog2(W + 1);
    localparam logic [RW:0]   DIV_T    = RW1'(DIV);
    localparam logic [CW-1:0] CNT_LOAD = CW'(W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_last_grant;
    logic [W-1:0]  r_sr;
    logic [RW-1:0] r_rem;
    logic [CW-1:0] r_cnt;
    logic [RW-1:0] r_res_rem;
    logic          r_res_div;
    logic          r_res_id;

    logic          w_grant_any;
    logic          w_grant_id;
    logic          w_accept;
    logic [RW:0]   w_trial;
    logic [RW-1:0] w_rem_nxt;

    // Contended grants alternate; last_grant resets to 1 so requester 0 wins first.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_id  = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            w_grant_any = 1'b1;
            w_grant_id  = ~r_last_grant;
        end else if (bus.req0_valid) begin
            w_grant_any = 1'b1;
            w_grant_id  = 1'b0;
        end else if (bus.req1_valid) begin
            w_grant_any = 1'b1;
            w_grant_id  = 1'b1;
        end
    end

    // rst_n gates the readies so nothing is accepted while reset is held.
    assign w_accept       = rst_n && (r_state == ST_IDLE) && w_grant_any;
    assign bus.req0_ready = w_accept && !w_grant_id;
    assign bus.req1_ready = w_accept && w_grant_id;

    // t = 2*rem + msb never exceeds 2*DIV-1, so one conditional subtract suffices.
    assign w_trial   = {r_rem, r_sr[W-1]};
    assign w_rem_nxt = (w_trial >= DIV_T) ? RW'(w_trial - DIV_T) : w_trial[RW-1:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)          w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (r_cnt == '0)       w_state_nxt = ST_DONE;
            ST_DONE:  if (bus.res_ready)     w_state_nxt = ST_IDLE;
            default:                         w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_sr         <= '0;
            r_rem        <= '0;
            r_cnt        <= '0;
            r_res_rem    <= '0;
            r_res_div    <= 1'b0;
            r_res_id     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_sr         <= w_grant_id ? bus.req1_data : bus.req0_data;
                        r_rem        <= '0;
                        r_cnt        <= CNT_LOAD;
                        r_res_id     <= w_grant_id;
                        r_last_grant <= w_grant_id;
                    end
                end
                ST_SHIFT: begin
                    if (r_cnt != '0) begin
                        r_rem <= w_rem_nxt;
                        r_sr  <= {r_sr[W-2:0], 1'b0};
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        // Result registers survive the handshake and the next SHIFT.
                        r_res_rem <= r_rem;
                        r_res_div <= (r_rem == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.res_valid = (r_state == ST_DONE);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.res_rem   = r_res_rem;
    assign bus.res_div   = r_res_div;
    assign bus.res_id    = r_res_id;

endmodule

// File: tb/tb_mod_check_sched.sv
// Bench for mod_check_sched: transaction-level model checked every cycle, plus
// directed literal cases and a small W=4/DIV=3 instance.
module tb_mod_check_sched;
    localparam int W   = 8;
    localparam int DIV = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mod_check_sched_if #(.W(W), .DIV(DIV)) bus ();
    mod_check_sched_if #(.W(4), .DIV(3))   bus2 ();

    mod_check_sched #(.W(W), .DIV(DIV)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    mod_check_sched #(.W(4), .DIV(3))   dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int n_cmp = 0;
    int n_err = 0;

    // model: phase 0 idle, 1 computing, 2 result presented
    int m_phase = 0, m_left = 0, m_last = 1;
    int m_exp_rem = 0, m_exp_div = 0, m_exp_id = 0;
    int m_hold_rem = 0, m_hold_div = 0, m_hold_id = 0;
    bit e_r0, e_r1;
    bit hs0 = 1'b0, hs1 = 1'b0;
    int n_results = 0;
    logic [31:0] cap_rem = '0, cap_div = '0, cap_id = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        hs0 = 1'b0;
        hs1 = 1'b0;
        if (!rst_n) begin
            chk("rst_ready0", bus.req0_ready, 0);
            chk("rst_ready1", bus.req1_ready, 0);
            chk("rst_valid",  bus.res_valid, 0);
            chk("rst_busy",   bus.busy, 0);
            chk("rst_rem",    bus.res_rem, 0);
            chk("rst_div",    bus.res_div, 0);
            chk("rst_id",     bus.res_id, 0);
            m_phase = 0; m_last = 1;
            m_hold_rem = 0; m_hold_div = 0; m_hold_id = 0;
        end else begin
            e_r0 = (m_phase == 0) && bus.req0_valid && (!bus.req1_valid || m_last == 1);
            e_r1 = (m_phase == 0) && bus.req1_valid && (!bus.req0_valid || m_last == 0);
            chk("ready0",    bus.req0_ready, e_r0);
            chk("ready1",    bus.req1_ready, e_r1);
            chk("busy",      bus.busy, m_phase != 0);
            chk("res_valid", bus.res_valid, m_phase == 2);
            if (m_phase == 2) begin
                chk("res_rem", bus.res_rem, m_exp_rem);
                chk("res_div", bus.res_div, m_exp_div);
                chk("res_id",  bus.res_id, m_exp_id);
            end else begin
                chk("hold_rem", bus.res_rem, m_hold_rem);
                chk("hold_div", bus.res_div, m_hold_div);
                chk("hold_id",  bus.res_id, (m_phase == 0) ? m_hold_id : m_exp_id);
            end
            case (m_phase)
                0: if (e_r0 || e_r1) begin
                    m_exp_id  = e_r1 ? 1 : 0;
                    m_exp_rem = (e_r1 ? int'(bus.req1_data) : int'(bus.req0_data)) % DIV;
                    m_exp_div = (m_exp_rem == 0) ? 1 : 0;
                    m_last    = m_exp_id;
                    m_left    = W + 1;
                    m_phase   = 1;
                    hs0 = e_r0;
                    hs1 = e_r1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                default: if (bus.res_ready === 1'b1) begin
                    cap_rem = 32'(bus.res_rem);
                    cap_div = 32'(bus.res_div);
                    cap_id  = 32'(bus.res_id);
                    n_results++;
                    m_hold_rem = m_exp_rem; m_hold_div = m_exp_div; m_hold_id = m_exp_id;
                    m_phase = 0;
                end
            endcase
        end
    end

    task automatic drive_req(input int id, input logic [W-1:0] d, input bit v);
        if (id == 0) begin bus.req0_valid = v; bus.req0_data = d; end
        else         begin bus.req1_valid = v; bus.req1_data = d; end
    endtask

    task automatic req_accept(input int id, input logic [W-1:0] d);
        int k;
        bit got;
        k = 0;
        drive_req(id, d, 1'b1);
        do begin
            @(posedge clk); #1; k++;
            got = (id == 0) ? hs0 : hs1;
        end while (!got && k < 100);
        chk("accept", got, 1);
        drive_req(id, d, 1'b0);
    endtask

    task automatic wait_result(input int er, input int ed, input int eid);
        int k;
        int r0;
        r0 = n_results;
        k = 0;
        while (bus.res_valid !== 1'b1 && k < 200) begin @(posedge clk); #1; k++; end
        chk("latency", k, W + 1);
        k = 0;
        while (n_results == r0 && k < 200) begin @(posedge clk); #1; k++; end
        chk("result_seen", n_results != r0, 1);
        chk("lit_rem", cap_rem, er);
        chk("lit_div", cap_div, ed);
        chk("lit_id",  cap_id, eid);
    endtask

    task automatic wait_grant(output bit g0, output bit g1);
        int k;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!(hs0 || hs1) && k < 100);
        g0 = hs0;
        g1 = hs1;
        chk("grant_seen", hs0 || hs1, 1);
    endtask

    initial begin
        int  k, r0;
        bit  g0, g1, got;
        logic [3:0] d2;

        bus.req0_valid = 0; bus.req0_data = '0;
        bus.req1_valid = 0; bus.req1_data = '0;
        bus.res_ready  = 1;
        bus2.req0_valid = 0; bus2.req0_data = '0;
        bus2.req1_valid = 0; bus2.req1_data = '0;
        bus2.res_ready  = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        req_accept(0, 8'd10);   wait_result(0, 1, 0);
        req_accept(1, 8'd7);    wait_result(2, 0, 1);
        req_accept(1, 8'hFF);   wait_result(0, 1, 1);
        req_accept(1, 8'd254);  wait_result(4, 0, 1);
        req_accept(1, 8'h00);   wait_result(0, 1, 1);

        // both held valid: grants must alternate starting with requester 0
        drive_req(0, 8'd25, 1'b1);
        drive_req(1, 8'd26, 1'b1);
        for (int i = 0; i < 4; i++) begin
            wait_grant(g0, g1);
            chk("rr_grant", g1, i % 2);
            wait_result(i % 2, (i % 2) ? 0 : 1, i % 2);
        end

        // result backpressure with both requesters still valid
        bus.res_ready = 0;
        wait_grant(g0, g1);
        chk("bp_grant0", g0, 1);
        k = 0;
        while (bus.res_valid !== 1'b1 && k < 200) begin @(posedge clk); #1; k++; end
        chk("bp_latency", k, W + 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid",  bus.res_valid, 1);
            chk("bp_rem",    bus.res_rem, 0);
            chk("bp_div",    bus.res_div, 1);
            chk("bp_id",     bus.res_id, 0);
            chk("bp_busy",   bus.busy, 1);
            chk("bp_ready0", bus.req0_ready, 0);
            chk("bp_ready1", bus.req1_ready, 0);
        end
        bus.res_ready = 1;
        wait_grant(g0, g1);
        chk("bp_next_grant1", g1, 1);
        wait_result(1, 0, 1);
        drive_req(0, 8'd0, 1'b0);
        drive_req(1, 8'd0, 1'b0);

        // reset in the 4th SHIFT cycle discards the word
        req_accept(0, 8'd99);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",  bus.busy, 0);
        chk("mid_rst_valid", bus.res_valid, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        r0 = n_results;
        repeat (W + 6) @(posedge clk);
        #1;
        chk("no_result_after_rst", n_results - r0, 0);
        req_accept(1, 8'd13);   wait_result(3, 0, 1);

        // randomized traffic, model checks every cycle
        r0 = n_results;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (hs0) bus.req0_valid = 0;
            else if (bus.req0_valid) begin
                if ($urandom_range(15) == 0) bus.req0_valid = 0;
            end else if ($urandom_range(2) == 0) begin
                bus.req0_valid = 1;
                bus.req0_data  = ($urandom_range(7) == 0) ? '0 : W'($urandom);
            end
            if (hs1) bus.req1_valid = 0;
            else if (bus.req1_valid) begin
                if ($urandom_range(15) == 0) bus.req1_valid = 0;
            end else if ($urandom_range(2) == 0) begin
                bus.req1_valid = 1;
                bus.req1_data  = ($urandom_range(7) == 0) ? '1 : W'($urandom);
            end
            bus.res_ready = ($urandom_range(3) != 0);
        end
        bus.req0_valid = 0;
        bus.req1_valid = 0;
        bus.res_ready  = 1;
        repeat (3 * W) @(posedge clk);
        #1;
        chk("rand_progress", n_results > r0 + 50, 1);

        // W=4, DIV=3 instance
        for (int i = 0; i < 2; i++) begin
            d2 = (i == 0) ? 4'b1111 : 4'b0111;
            if (i == 0) begin bus2.req0_valid = 1; bus2.req0_data = d2; end
            else        begin bus2.req1_valid = 1; bus2.req1_data = d2; end
            k = 0;
            got = 0;
            while (!got && k < 50) begin
                @(negedge clk);
                got = (i == 0) ? bus2.req0_ready : bus2.req1_ready;
                k++;
            end
            chk("w4_accept", got, 1);
            @(posedge clk); #1;
            bus2.req0_valid = 0;
            bus2.req1_valid = 0;
            k = 0;
            while (bus2.res_valid !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
            chk("w4_latency", k, 5);
            chk("w4_rem", bus2.res_rem, (i == 0) ? 0 : 1);
            chk("w4_div", bus2.res_div, (i == 0) ? 1 : 0);
            chk("w4_id",  bus2.res_id, i);
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
